// File: rtl/dds_multi_voice.sv
// Multi-voice sample-rate DDS: one shared registered sine ROM is time-multiplexed
// over the voices, and their scaled waveforms are summed into one offset-binary sample.
module dds_multi_voice #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned SAMPLE_DIV  = 256
) (
    input  logic                          clk,
    input  logic                          rst_active_low,
    input  logic [NUM_CH*PHASE_WIDTH-1:0] freq_word,
    input  logic [NUM_CH*2-1:0]           wave_sel,
    input  logic [NUM_CH*6-1:0]           vol,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH-1:0]             phase_rst,
    output logic [15:0]                   sample_out,
    output logic                          sample_valid,
    output logic                          clip
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
    localparam int unsigned ACC_W = 16 + $clog2(NUM_CH) + 1;

    localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO   = -(ACC_W'(32768));

    if (SAMPLE_DIV < NUM_CH + 5) begin : g_div_check
        $error("SAMPLE_DIV must be at least NUM_CH+5");
    end
    if (PHASE_WIDTH < 18) begin : g_pw_check
        $error("PHASE_WIDTH must be at least 18");
    end

    // Quarter-wave Taylor series in Q30, folded to full wave; round(32767*sin(2*pi*idx/512)).
    function automatic logic signed [15:0] sine_entry(input int unsigned idx);
        longint      x;
        longint      term;
        longint      s;
        int unsigned j;
        j = idx % 128;
        if (((idx / 128) % 2) == 1) j = 128 - j;
        x    = (longint'(j) * 64'sd3373259426) / 64'sd256;
        term = x;
        s    = x;
        for (int unsigned n = 1; n <= 7; n++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        s = (s * 64'sd32767 + (longint'(1) <<< 29)) >>> 30;
        return (idx >= 256) ? -16'(s) : 16'(s);
    endfunction

    logic signed [15:0] sine_rom [512];
    for (genvar gi = 0; gi < 512; gi++) begin : g_rom
        localparam logic signed [15:0] ENTRY = sine_entry(gi);
        assign sine_rom[gi] = ENTRY;
    end

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUTPUT} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CH_W-1:0]         ch_idx;
    logic [PHASE_WIDTH-1:0]  phase [NUM_CH];
    logic [NUM_CH-1:0]       rst_pend;

    logic                    issue;
    logic [PHASE_WIDTH-1:0]  cur_freq;
    logic [PHASE_WIDTH-1:0]  issue_p;
    logic                    cur_en;

    logic                    s1_vld, s2_vld, s3_vld;
    logic [16:0]             s1_top, s2_top;
    logic [1:0]              s1_sel, s2_sel;
    logic [5:0]              s1_vol, s2_vol;
    logic                    s1_en, s2_en;
    logic signed [15:0]      lut_q;
    logic signed [15:0]      s3;

    logic signed [15:0]      wave;
    logic [15:0]             tri_t;
    logic signed [21:0]      prod;
    logic signed [15:0]      scaled;

    logic signed [ACC_W-1:0] acc, s3_add, acc_sum;
    logic [15:0]             sat;
    logic                    sat_hit;

    assign issue = (state == SCAN);

    always_comb begin
        cur_freq = freq_word[ch_idx * PHASE_WIDTH +: PHASE_WIDTH];
        cur_en   = ch_en[ch_idx];
        issue_p  = rst_pend[ch_idx] ? '0 : phase[ch_idx];
    end

    // A pulse landing on the channel's own issue cycle stays pending for the next sample.
    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            for (int unsigned c = 0; c < NUM_CH; c++) phase[c] <= '0;
            rst_pend <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (issue && ch_idx == CH_W'(c)) begin
                    phase[c]    <= cur_en ? issue_p + cur_freq : '0;
                    rst_pend[c] <= phase_rst[c];
                end else begin
                    rst_pend[c] <= rst_pend[c] | phase_rst[c];
                end
            end
        end
    end

    always_comb begin
        tri_t = s2_top[16] ? ~s2_top[15:0] : s2_top[15:0];
        unique case (s2_sel)
            2'b00:   wave = lut_q;
            2'b01:   wave = s2_top[16] ? 16'sh8000 : 16'sh7FFF;
            2'b10:   wave = s2_top[16:1] ^ 16'h8000;
            default: wave = tri_t ^ 16'h8000;
        endcase
        prod   = 22'(wave) * 22'($signed({1'b0, s2_vol}));
        scaled = 16'(prod >>> 6);
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
            s1_top <= '0;
            s2_top <= '0;
            s1_sel <= '0;
            s2_sel <= '0;
            s1_vol <= '0;
            s2_vol <= '0;
            s1_en  <= 1'b0;
            s2_en  <= 1'b0;
            lut_q  <= '0;
            s3     <= '0;
        end else begin
            s1_vld <= issue;
            s1_top <= issue_p[PHASE_WIDTH-1 -: 17];
            s1_sel <= wave_sel[ch_idx * 2 +: 2];
            s1_vol <= vol[ch_idx * 6 +: 6];
            s1_en  <= issue & cur_en;
            s2_vld <= s1_vld;
            lut_q  <= sine_rom[s1_top[16:8]];
            s2_top <= s1_top;
            s2_sel <= s1_sel;
            s2_vol <= s1_vol;
            s2_en  <= s1_en;
            s3_vld <= s2_vld;
            s3     <= s2_en ? scaled : '0;
        end
    end

    // The last voice's contribution is folded in combinationally during OUTPUT.
    always_comb begin
        s3_add  = s3_vld ? ACC_W'(s3) : '0;
        acc_sum = acc + s3_add;
        sat_hit = 1'b0;
        sat     = acc_sum[15:0];
        if (acc_sum > SAT_HI) begin
            sat     = 16'h7FFF;
            sat_hit = 1'b1;
        end else if (acc_sum < SAT_LO) begin
            sat     = 16'h8000;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state        <= IDLE;
            cnt          <= '0;
            ch_idx       <= '0;
            acc          <= '0;
            sample_out   <= 16'h8000;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
        end else begin
            cnt          <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            sample_valid <= 1'b0;
            if (cnt == '0) acc <= '0;
            else if (s3_vld) acc <= acc_sum;
            unique case (state)
                IDLE: begin
                    if (cnt == '0) begin
                        state  <= SCAN;
                        ch_idx <= '0;
                    end
                end
                SCAN: begin
                    if (ch_idx == CH_LAST) state <= DRAIN;
                    else ch_idx <= ch_idx + CH_W'(1);
                end
                DRAIN: begin
                    if (!s1_vld) state <= OUTPUT;
                end
                OUTPUT: begin
                    sample_out   <= sat ^ 16'h8000;
                    clip         <= sat_hit;
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_multi_voice.sv
// Directed bench for dds_multi_voice (4 voices, 16-clock sample period, 32-bit phase).
module tb_dds_multi_voice;

    localparam int NCH = 4;
    localparam int PW  = 32;
    localparam int DIV = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH*PW-1:0] freq_word;
    logic [NCH*2-1:0]  wave_sel;
    logic [NCH*6-1:0]  vol;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    phase_rst;
    logic [15:0]       sample_out;
    logic              sample_valid;
    logic              clip;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    dds_multi_voice #(.NUM_CH(NCH), .PHASE_WIDTH(PW), .SAMPLE_DIV(DIV)) dut (
        .clk            (clk),
        .rst_active_low (rst_n),
        .freq_word      (freq_word),
        .wave_sel       (wave_sel),
        .vol            (vol),
        .ch_en          (ch_en),
        .phase_rst      (phase_rst),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .clip           (clip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        n_total++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_strobe(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_strobe"}, 32'(ok), 32'd1);
    endtask

    task automatic expect_sample(input string tag, input logic [15:0] exp_out, input logic exp_clip);
        wait_strobe(tag);
        check(tag, 32'(sample_out), 32'(exp_out));
        check({tag, "_clip"}, 32'(clip), 32'(exp_clip));
    endtask

    task automatic set_ch(input int c, input logic [1:0] sel, input logic [5:0] v,
                          input logic [31:0] f, input logic en);
        freq_word[c*PW +: PW] = f;
        wave_sel[c*2 +: 2]    = sel;
        vol[c*6 +: 6]         = v;
        ch_en[c]              = en;
    endtask

    task automatic pulse_rst(input logic [NCH-1:0] mask);
        phase_rst = mask;
        tick();
        phase_rst = '0;
    endtask

    function automatic int vscale(input int w, input int v);
        return (w * v) >>> 6;
    endfunction

    function automatic logic [15:0] ob(input int s);
        return 16'(s + 32768);
    endfunction

    function automatic int saw_w(input logic [31:0] p);
        logic [15:0] top;
        top = p[31:16];
        return int'(top) - 32768;
    endfunction

    initial begin
        int          first;
        int          gap;
        int          seen;
        int          ref_v;
        logic [31:0] ph;

        freq_word = '0;
        wave_sel  = '0;
        vol       = '0;
        ch_en     = '0;
        phase_rst = '0;

        // Reset values, then strobe timing after release.
        repeat (3) tick();
        check("reset_out", 32'(sample_out), 32'h8000);
        check("reset_valid", 32'(sample_valid), 32'd0);
        check("reset_clip", 32'(clip), 32'd0);
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (sample_valid) begin
                first = i;
                break;
            end
        end
        check("first_valid_cycle", 32'(first), 32'd8);
        gap = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (sample_valid) begin
                gap = i;
                break;
            end
        end
        check("strobe_period", 32'(gap), 32'd16);
        check("idle_out", 32'(sample_out), 32'h8000);
        check("idle_clip", 32'(clip), 32'd0);

        // Single square voice at half-rate alternates high/low.
        set_ch(0, 2'b01, 6'd63, 32'h8000_0000, 1'b1);
        expect_sample("sq0", 16'hFDFF, 1'b0);
        expect_sample("sq1", 16'h0200, 1'b0);
        expect_sample("sq2", 16'hFDFF, 1'b0);
        expect_sample("sq3", 16'h0200, 1'b0);

        // Two voices just below and just above positive full scale.
        set_ch(0, 2'b01, 6'd63, 32'h0, 1'b1);
        set_ch(1, 2'b01, 6'd1, 32'h0, 1'b1);
        pulse_rst(4'b0011);
        expect_sample("mix_below", 16'hFFFE, 1'b0);
        set_ch(1, 2'b01, 6'd2, 32'h0, 1'b1);
        expect_sample("mix_above", 16'hFFFF, 1'b1);

        // All four voices saturate positive, then negative.
        for (int c = 0; c < NCH; c++) set_ch(c, 2'b01, 6'd63, 32'h0, 1'b1);
        pulse_rst(4'hF);
        expect_sample("sat_pos", 16'hFFFF, 1'b1);
        for (int c = 0; c < NCH; c++) set_ch(c, 2'b10, 6'd63, 32'h0, 1'b1);
        pulse_rst(4'hF);
        expect_sample("sat_neg", 16'h0000, 1'b1);

        // Reset asserted three cycles into a scan.
        repeat (11) tick();
        rst_n = 1'b0;
        #1;
        check("midscan_rst_out", 32'(sample_out), 32'h8000);
        check("midscan_rst_valid", 32'(sample_valid), 32'd0);
        check("midscan_rst_clip", 32'(clip), 32'd0);
        seen = 0;
        repeat (20) begin
            tick();
            if (sample_valid) seen = 1;
        end
        check("no_strobe_in_reset", 32'(seen), 32'd0);
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (sample_valid) begin
                first = i;
                break;
            end
        end
        check("rerelease_valid_cycle", 32'(first), 32'd8);
        check("rerelease_out", 32'(sample_out), 32'h0000);
        check("rerelease_clip", 32'(clip), 32'd1);

        // Sine at one ROM step per sample, half volume.
        ch_en = '0;
        set_ch(0, 2'b00, 6'd32, 32'h0080_0000, 1'b1);
        pulse_rst(4'b0001);
        for (int k = 0; k <= 384; k++) begin
            wait_strobe("sine");
            if (k % 32 == 0) begin
                ref_v = int'(32767.0 * $sin(2.0 * 3.14159265358979 * k / 512.0));
                check_near($sformatf("sine_k%0d", k), int'(sample_out),
                           (ref_v >>> 1) + 32768, (k % 128 == 0) ? 0 : 1);
            end
        end

        // Saw with phase resets off and on the issue cycle, then disable/enable.
        set_ch(0, 2'b10, 6'd63, 32'h1000_0000, 1'b1);
        pulse_rst(4'b0001);
        ph = 32'h0;
        for (int k = 0; k < 3; k++) begin
            expect_sample($sformatf("saw%0d", k), ob(vscale(saw_w(ph), 63)), 1'b0);
            ph = ph + 32'h1000_0000;
        end
        repeat (3) tick();
        pulse_rst(4'b0001);
        expect_sample("saw_after_rst", 16'h0200, 1'b0);
        expect_sample("saw_step1", ob(vscale(saw_w(32'h1000_0000), 63)), 1'b0);
        ph = 32'h2000_0000;
        repeat (9) tick();
        pulse_rst(4'b0001);
        expect_sample("saw_rst_on_issue", ob(vscale(saw_w(ph), 63)), 1'b0);
        expect_sample("saw_rst_next", 16'h0200, 1'b0);
        ch_en[0] = 1'b0;
        expect_sample("saw_disabled", 16'h8000, 1'b0);
        ch_en[0] = 1'b1;
        expect_sample("saw_reenable", 16'h0200, 1'b0);
        expect_sample("saw_reenable1", 16'h11C0, 1'b0);

        // Triangle at quarter-cycle steps, including the phase wrap.
        set_ch(0, 2'b11, 6'd63, 32'h4000_0000, 1'b1);
        pulse_rst(4'b0001);
        expect_sample("tri_0", 16'h0200, 1'b0);
        expect_sample("tri_q1", 16'h8000, 1'b0);
        expect_sample("tri_q2", 16'hFDFF, 1'b0);
        expect_sample("tri_q3", 16'h7FFF, 1'b0);
        expect_sample("tri_wrap", 16'h0200, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
